seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Display controller that owns the board's 4-digit seven-segment display.
- Selects one of four 16-bit CPU-side values (e.g. PC, ALU result, register readback, cycle count) and converts it to BCD with a sequential double-dabble engine.
- Refreshes the BCD snapshot periodically or on a request/acknowledge handshake.
- Time-multiplexes the four digits onto shared anode/segment pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (≥2).
- CONV_PERIOD, 5000000: clk cycles between automatic re-conversions (≥32).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk rising edge)
- src0..src3  in  16 each  candidate unsigned values
- src_sel  in  2  source select, sampled only when a conversion starts
- upd_req  in  1  level request for an immediate conversion
- upd_ack  out  1  one-cycle pulse when a request-triggered conversion commits
- busy  out  1  conversion in progress
- bcd_out  out  16  committed 4-digit BCD, thousands in [15:12]
- ovf  out  1  committed value >9999
- active_anode  out  4  active-low one-hot digit enable
- seg  out  7  active-low segments, a at bit 6 … g at bit 0

Behaviour:
- Reset values:
  - state IDLE; busy 0; upd_ack 0; bcd_out 0; ovf 0; pend 0.
  - Scan index 0; refresh and period counters 0.
  - active_anode 1110; seg 0000001 (shows 0).
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - Trigger = upd_req | pend | period_tick.
  - On trigger: load bin <= src[src_sel]; clear 20-bit BCD accumulator; iter <= 0; set req_cause = upd_req|pend; clear pend; go CONVERT.
- CONVERT, 16 cycles, one per bit:
  - Add 3 to every accumulator nibble ≥5.
  - Then shift {acc,bin} left by 1.
  - At iter==15, go COMMIT.
- COMMIT, 1 cycle:
  - bcd_out <= acc[15:0]; ovf <= (acc[19:16]!=0).
  - upd_ack = req_cause.
  - Go IDLE.
- Latency:
  - Trigger sampled in cycle 0; busy high cycles 1–17; upd_ack high in cycle 17.
  - New bcd_out/ovf visible from cycle 18.
- Requests while busy:
  - upd_req high while not IDLE sets pend.
  - pend starts a new conversion in the first IDLE cycle after COMMIT, with src re-sampled.
  - Multiple requests while busy collapse into one.
- src/src_sel changes during CONVERT have no effect on the running conversion.
- Period counter:
  - Free-running, 0..CONV_PERIOD-1; period_tick on wrap.
  - A tick while not IDLE is dropped, not queued.
- Scan:
  - Refresh counter 0..REFRESH_DIV-1; on wrap, scan index 0→1→2→3→0.
  - active_anode: 1110, 1101, 1011, 0111 for units, tens, hundreds, thousands.
  - seg is the registered decode of the selected bcd_out nibble and updates on the same edge as active_anode.
  - Decode: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; codes 10–15 = 1111111.
- ovf=1: every digit presents code 4'hF (blank); bcd_out still holds the low 4 digits.
- Reset mid-conversion: abort; no upd_ack; pend cleared; all outputs return to reset values.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: thousands/hundreds/tens digits present code 4'hF while they and every higher digit are 0. Units always shows.
- Not defined: all four digits always show, including leading zeros.

Decomposition:
- Package seg_disp_pkg:
  - state enum {IDLE, CONVERT, COMMIT}
  - BLANK_CODE = 4'hF
  - ANODE_SCAN[0:3] constant
  - SEG_BLANK = 7'b1111111
- Sub-module seg7_decoder: combinational 4-bit code → 7-bit active-low segments. The scheduler registers its output.

Test Plan:
- Reset with rst=0, then src0=1234, src_sel=0, one-cycle upd_req → busy high 17 cycles; upd_ack pulse in cycle 17; bcd_out=16'h1234 from cycle 18; ovf=0.
- src2=65535, src_sel=2, upd_req → bcd_out=16'h5535, ovf=1; seg=1111111 on every anode.
- REFRESH_DIV=4, value 1234 committed → anode sequence 1110/1101/1011/0111, 4 cycles each; seg 1001100/0000110/0010010/1001111; wraps to 1110.
- upd_req in cycle 5 of a conversion, with src0 changed 1234→42 → first commit 1234 with ack; second conversion starts the cycle after COMMIT; commits 0042 with a second ack.
- CONVERT_PERIOD=64, no requests, src1 switched 7→9 with src_sel=1 → bcd_out becomes 16'h0009 within 64+18 cycles; upd_ack stays 0.
- rst=0 at cycle 8 of a conversion → next cycle busy=0, bcd_out=0, anode 1110, seg 0000001, no ack. With LEADING_ZERO_BLANK_EN, value 7 → three upper digits 1111111, units 0001111.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Also provides the per-step double-dabble nibble correction.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_e;

   localparam logic [3:0] BLANK_CODE        = 4'hF;
   localparam logic [6:0] SEG_BLANK         = 7'b1111111;
   localparam logic [3:0] ANODE_SCAN [0:3]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
   function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
      logic [19:0] res;
      res = acc;
      for (int i = 0; i < 5; i++) begin
         if (acc[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
         end else begin
            res[i*4 +: 4] = acc[i*4 +: 4];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit code to active-low segments (a at bit 6 .. g at bit 0).
// Codes 10-15 light nothing, which is how blanked digits are shown.
module seg7_decoder
   import seg_disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   // Digit code lookup
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_scheduler.sv
// Four-digit seven-segment controller: selects a 16-bit source, converts it to BCD
// with a sequential double-dabble engine and time-multiplexes the digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the units.
module seg_display_scheduler
   import seg_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CONV_PERIOD = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] src0,
   input  logic [15:0] src1,
   input  logic [15:0] src2,
   input  logic [15:0] src3,
   input  logic [1:0]  src_sel,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic        busy,
   output logic [15:0] bcd_out,
   output logic        ovf,
   output logic [3:0]  active_anode,
   output logic [6:0]  seg
);

   localparam int unsigned RW = (REFRESH_DIV > 32'd2) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned PW = $clog2(CONV_PERIOD);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 32'd1);
   localparam logic [PW-1:0] PERIOD_MAX  = PW'(CONV_PERIOD - 32'd1);

   state_e        state_q, state_d;
   logic [15:0]   bin_q, bin_d;
   logic [19:0]   acc_q, acc_d;
   logic [3:0]    iter_q, iter_d;
   logic          req_cause_q, req_cause_d;
   logic          pend_q, pend_d;
   logic          busy_q, busy_d;
   logic          upd_ack_q, upd_ack_d;
   logic [15:0]   bcd_q, bcd_d;
   logic          ovf_q, ovf_d;
   logic [RW-1:0] refresh_q, refresh_d;
   logic [PW-1:0] period_q, period_d;
   logic [1:0]    scan_q, scan_d;
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q;

   logic [15:0]   src_mux_s;
   logic [35:0]   shifted_s;
   logic          period_tick_s;
   logic          trigger_s;
   logic [3:0]    digit_s;
   logic          lead_zero_s;
   logic [3:0]    code_s;
   logic [6:0]   seg_dec_s;

   // Conversion FSM: capture source, 16 dabble/shift steps, then commit
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      acc_d       = acc_q;
      iter_d      = iter_q;
      req_cause_d = req_cause_q;
      pend_d      = pend_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      shifted_s   = {dabble_adjust(acc_q), bin_q} << 1;
      case (src_sel)
         2'd0:    src_mux_s = src0;
         2'd1:    src_mux_s = src1;
         2'd2:    src_mux_s = src2;
         2'd3:    src_mux_s = src3;
         default: src_mux_s = src0;
      endcase
      trigger_s = upd_req | pend_q | period_tick_s;
      case (state_q)
         IDLE: begin
            if (trigger_s) begin
               bin_d       = src_mux_s;
               acc_d       = 20'd0;
               iter_d      = 4'd0;
               req_cause_d = upd_req | pend_q;
               pend_d      = 1'b0;
               state_d     = CONVERT;
            end else begin
               state_d = IDLE;
            end
         end
         CONVERT: begin
            acc_d  = shifted_s[35:16];
            bin_d  = shifted_s[15:0];
            iter_d = iter_q + 4'd1;
            pend_d = pend_q | upd_req;
            if (iter_q == 4'd15) begin
               state_d = COMMIT;
            end else begin
               state_d = CONVERT;
            end
         end
         COMMIT: begin
            bcd_d   = acc_q[15:0];
            ovf_d   = (acc_q[19:16] != 4'd0);
            pend_d  = pend_q | upd_req;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d    = (state_d != IDLE);
      upd_ack_d = (state_d == COMMIT) & req_cause_q;
   end

   // Period/refresh counters and selection of the digit shown next
   always_comb begin
      period_tick_s = (period_q == PERIOD_MAX);
      if (period_tick_s) begin
         period_d = {PW{1'b0}};
      end else begin
         period_d = period_q + PW'(1);
      end
      if (refresh_q == REFRESH_MAX) begin
         refresh_d = {RW{1'b0}};
         scan_d    = scan_q + 2'd1;
      end else begin
         refresh_d = refresh_q + RW'(1);
         scan_d    = scan_q;
      end
      // Decode from next-state values so seg and anode change together
      digit_s = bcd_d[{scan_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      case (scan_d)
         2'd3:    lead_zero_s = (bcd_d[15:12] == 4'd0);
         2'd2:    lead_zero_s = (bcd_d[15:8] == 8'd0);
         2'd1:    lead_zero_s = (bcd_d[15:4] == 12'd0);
         default: lead_zero_s = 1'b0;
      endcase
`else
      lead_zero_s = 1'b0;
`endif
      if (ovf_d || lead_zero_s) begin
         code_s = BLANK_CODE;
      end else begin
         code_s = digit_s;
      end
      anode_d = ANODE_SCAN[scan_d];
   end

   seg7_decoder u_dec (
      .code (code_s),
      .seg  (seg_dec_s)
   );

   // Conversion state registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bin_q       <= 16'd0;
         acc_q       <= 20'd0;
         iter_q      <= 4'd0;
         req_cause_q <= 1'b0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         upd_ack_q   <= 1'b0;
         bcd_q       <= 16'd0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         acc_q       <= acc_d;
         iter_q      <= iter_d;
         req_cause_q <= req_cause_d;
         pend_q      <= pend_d;
         busy_q      <= busy_d;
         upd_ack_q   <= upd_ack_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
      end
   end

   // Counter and display scan registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         refresh_q <= {RW{1'b0}};
         period_q  <= {PW{1'b0}};
         scan_q    <= 2'd0;
         anode_q   <= ANODE_SCAN[0];
         seg_q     <= 7'b0000001;
      end else begin
         refresh_q <= refresh_d;
         period_q  <= period_d;
         scan_q    <= scan_d;
         anode_q   <= anode_d;
         seg_q     <= seg_dec_s;
      end
   end

   assign upd_ack      = upd_ack_q;
   assign busy         = busy_q;
   assign bcd_out      = bcd_q;
   assign ovf          = ovf_q;
   assign active_anode = anode_q;
   assign seg          = seg_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: request-driven instance plus a
// short-period instance for automatic refresh.
module tb_seg_display_scheduler;

   typedef struct packed {
      logic [15:0] bcd;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] src0, src1, src2, src3;
   logic [1:0]  src_sel;
   logic        upd_req;
   logic        upd_ack_a, busy_a, ovf_a;
   logic [15:0] bcd_a;
   logic [3:0]  anode_a;
   logic [6:0]  seg_a;

   logic [15:0] src1_b;
   logic [15:0] zero_b;
   logic [1:0]  sel_b;
   logic        req_b;
   logic        upd_ack_b, busy_b, ovf_b;
   logic [15:0] bcd_b;
   logic [3:0]  anode_b;
   logic [6:0]  seg_b;

   int   n_checks = 0;
   int   n_errors = 0;
   int   ack_b_count = 0;
   exp_t exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] UPPER_ZERO = 7'b1111111;
`else
   localparam logic [6:0] UPPER_ZERO = 7'b0000001;
`endif

   seg_display_scheduler #(.REFRESH_DIV(4), .CONV_PERIOD(5000000)) dut_a (
      .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2), .src3(src3),
      .src_sel(src_sel), .upd_req(upd_req), .upd_ack(upd_ack_a), .busy(busy_a),
      .bcd_out(bcd_a), .ovf(ovf_a), .active_anode(anode_a), .seg(seg_a)
   );

   seg_display_scheduler #(.REFRESH_DIV(4), .CONV_PERIOD(64)) dut_b (
      .clk(clk), .rst(rst), .src0(zero_b), .src1(src1_b), .src2(zero_b), .src3(zero_b),
      .src_sel(sel_b), .upd_req(req_b), .upd_ack(upd_ack_b), .busy(busy_b),
      .bcd_out(bcd_b), .ovf(ovf_b), .active_anode(anode_b), .seg(seg_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic pulse_req();
      @(posedge clk); #1;
      upd_req = 1'b1;
      @(posedge clk); #1;
      upd_req = 1'b0;
   endtask

   // Lock onto the units digit, then check one full scan round and the wrap
   task automatic check_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] exp_seg [0:3];
      logic [3:0] exp_an [0:3];
      logic [3:0] prev;
      bit         synced;
      exp_seg = '{e0, e1, e2, e3};
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      synced  = 1'b0;
      @(negedge clk);
      prev = anode_a;
      for (int i = 0; i < 40 && !synced; i++) begin
         @(negedge clk);
         if (anode_a == 4'b1110 && prev == 4'b0111) synced = 1'b1;
         else prev = anode_a;
      end
      check_eq({tag, "_sync"}, synced, 1);
      if (synced) begin
         for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            check_eq({tag, "_anode"}, anode_a, exp_an[i/4]);
            check_eq({tag, "_seg"}, seg_a, exp_seg[i/4]);
         end
         @(negedge clk);
         check_eq({tag, "_wrap"}, anode_a, 4'b1110);
      end
   endtask

   // Scoreboard: each ack pops the expected commit, checked the following cycle
   initial begin : sb_monitor
      exp_t cur;
      bit   cmp_pending;
      cmp_pending = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (cmp_pending) begin
            check_eq("sb_bcd", bcd_a, cur.bcd);
            check_eq("sb_ovf", ovf_a, cur.ovf);
            cmp_pending = 1'b0;
         end
         if (upd_ack_a) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_unexpected_ack", upd_ack_a, 1'b0);
            end else begin
               cur = exp_q.pop_front();
               cmp_pending = 1'b1;
            end
         end
      end
   end

   initial begin : ack_b_monitor
      forever begin
         @(negedge clk);
         if (upd_ack_b) ack_b_count++;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int  ack_cnt;
      int  busy_cnt;
      bit  found;
      rst = 1'b0; upd_req = 1'b0; src_sel = 2'd0;
      src0 = 16'd0; src1 = 16'd0; src2 = 16'd0; src3 = 16'd0;
      src1_b = 16'd7; zero_b = 16'd0; sel_b = 2'd1; req_b = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy_a, 1'b0);
      check_eq("rst_ack", upd_ack_a, 1'b0);
      check_eq("rst_bcd", bcd_a, 16'h0000);
      check_eq("rst_ovf", ovf_a, 1'b0);
      check_eq("rst_anode", anode_a, 4'b1110);
      check_eq("rst_seg", seg_a, 7'b0000001);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic request: 1234, busy cycles 1-17, ack in cycle 17
      src0 = 16'd1234; src_sel = 2'd0;
      exp_q.push_back('{bcd: 16'h1234, ovf: 1'b0});
      pulse_req();
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         check_eq("t1_busy", busy_a, (k <= 17));
         check_eq("t1_ack", upd_ack_a, (k == 17));
      end
      check_scan("scan1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

      // Overflow: 65535 keeps low digits, blanks every digit
      src2 = 16'd65535; src_sel = 2'd2;
      exp_q.push_back('{bcd: 16'h5535, ovf: 1'b1});
      pulse_req();
      repeat (18) @(negedge clk);
      check_eq("ovf_busy_done", busy_a, 1'b0);
      check_scan("ovf", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      // Requests while busy collapse into one follow-up conversion
      src0 = 16'd1234; src_sel = 2'd0;
      exp_q.push_back('{bcd: 16'h1234, ovf: 1'b0});
      exp_q.push_back('{bcd: 16'h0042, ovf: 1'b0});
      pulse_req();
      for (int k = 1; k <= 37; k++) begin
         @(negedge clk);
         check_eq("pend_busy", busy_a, (k <= 17) || (k >= 19 && k <= 35));
         check_eq("pend_ack", upd_ack_a, (k == 17) || (k == 35));
         if (k == 4) begin
            upd_req = 1'b1;
            src0 = 16'd42;
         end
         if (k == 7) upd_req = 1'b0;
      end
      check_scan("val42", 7'b0010010, 7'b1001100, UPPER_ZERO, UPPER_ZERO);

      src3 = 16'd7; src_sel = 2'd3;
      exp_q.push_back('{bcd: 16'h0007, ovf: 1'b0});
      pulse_req();
      repeat (18) @(negedge clk);
      check_scan("val7", 7'b0001111, UPPER_ZERO, UPPER_ZERO, UPPER_ZERO);

      // Reset in cycle 8 of a conversion, with a pending request queued
      src_sel = 2'd0;
      pulse_req();
      @(posedge clk); #1;
      upd_req = 1'b1;
      @(posedge clk); #1;
      upd_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("prerst_busy", busy_a, 1'b1);
      @(negedge clk);
      check_eq("midrst_busy", busy_a, 1'b0);
      check_eq("midrst_ack", upd_ack_a, 1'b0);
      check_eq("midrst_bcd", bcd_a, 16'h0000);
      check_eq("midrst_ovf", ovf_a, 1'b0);
      check_eq("midrst_anode", anode_a, 4'b1110);
      check_eq("midrst_seg", seg_a, 7'b0000001);
      @(posedge clk); #1;
      rst = 1'b1;
      ack_cnt = 0; busy_cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (upd_ack_a) ack_cnt++;
         if (busy_a) busy_cnt++;
      end
      check_eq("postrst_acks", ack_cnt, 0);
      check_eq("postrst_busy", busy_cnt, 0);

      // Automatic refresh on the short-period instance
      src1_b = 16'd9;
      found = 1'b0;
      for (int k = 0; k < 84 && !found; k++) begin
         @(negedge clk);
         if (bcd_b == 16'h0009) found = 1'b1;
      end
      check_eq("period_found", found, 1'b1);
      check_eq("period_bcd", bcd_b, 16'h0009);
      check_eq("period_ovf", ovf_b, 1'b0);
      check_eq("period_no_ack", ack_b_count, 0);

      repeat (3) @(negedge clk);
      check_eq("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
